// File: rtl/dot_acc_pkg.sv
// Shared types and helpers for the dot_acc block.
// Defining DOT_ACC_SAT_EN selects a saturating accumulator; the default build wraps.
package dot_acc_pkg;
    localparam int LANES  = 8;
    localparam int LANE_W = 32;
    localparam int HALF_W = 16;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic signed [31:0] prod_t;
    typedef logic signed [34:0] dsum_t;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Signed add clamped to a width-bit range; inputs must already fit in width bits (width <= 63).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] sum, mx, mn;
        sum = a + b;
        mx  = (64'sd1 <<< (width - 1)) - 64'sd1;
        mn  = -mx - 64'sd1;
        if (sum > mx)      sat_add = mx;
        else if (sum < mn) sat_add = mn;
        else               sat_add = sum;
    endfunction
endpackage

// File: rtl/dot_acc_tree.sv
// Input register, 8 signed 16x16 multipliers and a 3-level adder tree.
// A sum leaves four edges after the input register captures its vector.
module dot_tree
    import dot_acc_pkg::*;
(
    input  logic                    clk_data,
    input  logic                    rst_n,
    input  logic [LANES*LANE_W-1:0] vec_i,
    input  logic                    vec_valid_i,
    input  logic                    clear_i,
    output dsum_t                   s_o,
    output logic                    sum_valid_o,
    output logic                    busy_o
);
    logic [4:0]         vld_q;
    lane_t              lane_q [LANES];
    prod_t              prod_q [LANES];
    logic signed [32:0] pair_q [4];
    logic signed [33:0] quad_q [2];
    dsum_t              sum_q;

    always_ff @(posedge clk_data) begin
        if (!rst_n || clear_i) vld_q <= '0;
        else                   vld_q <= {vld_q[3:0], vec_valid_i};
    end

    // Data stages only move when their valid does; no reset needed on the datapath.
    always_ff @(posedge clk_data) begin
        for (int k = 0; k < LANES; k++) begin
            if (vec_valid_i) lane_q[k] <= vec_i[k*LANE_W +: LANE_W];
            if (vld_q[0])
                prod_q[k] <= prod_t'($signed(lane_q[k][LANE_W-1:HALF_W]))
                           * prod_t'($signed(lane_q[k][HALF_W-1:0]));
        end
        for (int i = 0; i < 4; i++)
            if (vld_q[1]) pair_q[i] <= 33'(prod_q[2*i]) + 33'(prod_q[2*i+1]);
        for (int i = 0; i < 2; i++)
            if (vld_q[2]) quad_q[i] <= 34'(pair_q[2*i]) + 34'(pair_q[2*i+1]);
        if (vld_q[3]) sum_q <= dsum_t'(quad_q[0]) + dsum_t'(quad_q[1]);
    end

    assign s_o         = sum_q;
    assign sum_valid_o = vld_q[4];
    assign busy_o      = |vld_q;
endmodule

// File: rtl/dot_acc.sv
// Accumulates ACC_LEN dot products and presents them through a valid/ready output register.
// Optional macro DOT_ACC_SAT_EN: saturate each accumulator add instead of wrapping.
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 40
) (
    input  logic                    clk_data,
    input  logic                    rst_n,
    input  logic [LANES*LANE_W-1:0] vec_i,
    input  logic                    vec_valid_i,
    input  logic                    clear_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    acc_valid_o,
    input  logic                    acc_ready_i,
    output logic                    busy_o,
    output logic                    overrun_o
);
    localparam int                CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(ACC_LEN - 1);

    dsum_t                   s;
    logic                    sum_valid, pipe_busy, done;
    logic signed [ACC_W-1:0] s_ext, sum_d;
    logic signed [ACC_W-1:0] acc_q, res_q;
    logic [CNT_W-1:0]        cnt_q;
    state_t                  state_q;
    logic                    acc_valid_q, overrun_q;

    dot_tree u_tree (
        .clk_data    (clk_data),
        .rst_n       (rst_n),
        .vec_i       (vec_i),
        .vec_valid_i (vec_valid_i),
        .clear_i     (clear_i),
        .s_o         (s),
        .sum_valid_o (sum_valid),
        .busy_o      (pipe_busy)
    );

    assign s_ext = ACC_W'(s);

    // acc_q is always 0 in IDLE, so acc+s also covers the "first product" case.
    always_comb begin
`ifdef DOT_ACC_SAT_EN
        sum_d = ACC_W'(sat_add(64'(acc_q), 64'(s_ext), ACC_W));
`else
        sum_d = acc_q + s_ext;
`endif
        done  = sum_valid && ((state_q == ACCUM && cnt_q == LAST) ||
                              (state_q == IDLE && ACC_LEN == 1));
    end

    always_ff @(posedge clk_data) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            acc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (sum_valid) begin
                if (done) begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    acc_q   <= sum_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= ACCUM;
                end
            end
            // A new result always wins; overrun only if the old one was never taken.
            if (done) begin
                res_q       <= sum_d;
                acc_valid_q <= 1'b1;
                if (acc_valid_q && !acc_ready_i) overrun_q <= 1'b1;
            end else if (acc_valid_q && acc_ready_i) begin
                acc_valid_q <= 1'b0;
            end
        end
    end

    assign acc_o       = res_q;
    assign acc_valid_o = acc_valid_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = pipe_busy | (state_q == ACCUM);
endmodule
